// File: rtl/reg_register_int_ctrl.sv
// ---------------------------------------------------------------------------
// reg_register_int_ctrl
//
// Interrupt controller register bank with three registers and INT_NUM
// channels:
//   ENABLE (addr 0, RW)  : masks which STATUS bits drive int_out
//   STATUS (addr 1, W1C) : sticky per-channel event flags
//   RAW    (addr 2, RO)  : source levels as sampled on the previous edge
//   addr 3               : reserved, reads 0, writes ignored
// Each channel detects either rising edges or levels, chosen by INT_EDGE.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   int_src         raw interrupt sources, already synchronous to clk
//   reg_wr_sel      register access select
//   reg_wr_rd       access direction (1 = write, 0 = read)
//   reg_addr        register address
//   reg_wr_data     write data
//   reg_rd_out      registered read data, held between reads
//   reg_rd_vld      one-cycle pulse marking reg_rd_out as fresh
//   reg_wr_ack      one-cycle pulse one cycle after any write access
//   int_enable_out  current ENABLE contents
//   int_status_out  current STATUS contents
//   int_out         registered OR of (STATUS & ENABLE)
//
// Handshake: an access is taken on every edge where reg_wr_sel is high;
// there is no ready/backpressure, so the requester may issue one access per
// cycle. A read answers with reg_rd_vld high for exactly the cycle after the
// access edge; a write answers with reg_wr_ack in that same cycle.
// ---------------------------------------------------------------------------
module reg_register_int_ctrl #(
   parameter int                 REG_WIDTH      = 32,
   parameter int                 INT_NUM        = 8,
   parameter logic [INT_NUM-1:0] INT_EDGE       = {INT_NUM{1'b1}},
   parameter logic [INT_NUM-1:0] ENABLE_DEFAULT = {INT_NUM{1'b0}}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [INT_NUM-1:0]   int_src,
   input  logic                 reg_wr_sel,
   input  logic                 reg_wr_rd,
   input  logic [1:0]           reg_addr,
   input  logic [REG_WIDTH-1:0] reg_wr_data,
   output logic [REG_WIDTH-1:0] reg_rd_out,
   output logic                 reg_rd_vld,
   output logic                 reg_wr_ack,
   output logic [INT_NUM-1:0]   int_enable_out,
   output logic [INT_NUM-1:0]   int_status_out,
   output logic                 int_out
);

   localparam logic [1:0] ADDR_ENABLE = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_RAW    = 2'd2;

   logic                 wr_acc;
   logic                 rd_acc;
   logic [INT_NUM-1:0]   src_q;
   logic [INT_NUM-1:0]   enable_q;
   logic [INT_NUM-1:0]   status_q;
   logic [INT_NUM-1:0]   event_vec;
   logic [INT_NUM-1:0]   clr_mask;
   logic [INT_NUM-1:0]   status_nxt;
   logic [REG_WIDTH-1:0] rd_word;
   logic [REG_WIDTH-1:0] rd_q;
   logic                 rd_vld_q;
   logic                 wr_ack_q;
   logic                 int_q;

   // Only the low INT_NUM bits of write data are ever stored.
   logic                 unused_wr_data;
   assign unused_wr_data = ^reg_wr_data;

   assign wr_acc = reg_wr_sel &  reg_wr_rd;
   assign rd_acc = reg_wr_sel & ~reg_wr_rd;

   // Per-channel event: rising edge for edge channels, plain level otherwise.
   assign event_vec = (INT_EDGE & int_src & ~src_q) | (~INT_EDGE & int_src);

   always_comb begin
      clr_mask = '0;
      if (wr_acc && (reg_addr == ADDR_STATUS)) begin
         clr_mask = reg_wr_data[INT_NUM-1:0];
      end
   end

   // OR-ing the event after the clear lets a same-cycle set win.
   assign status_nxt = (status_q & ~clr_mask) | event_vec;

   // Read mux uses the current (pre-update) register contents; unused upper
   // bits stay zero.
   always_comb begin
      rd_word = '0;
      case (reg_addr)
         ADDR_ENABLE: rd_word[INT_NUM-1:0] = enable_q;
         ADDR_STATUS: rd_word[INT_NUM-1:0] = status_q;
         ADDR_RAW:    rd_word[INT_NUM-1:0] = src_q;
         default:     rd_word = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_q    <= '0;
         enable_q <= ENABLE_DEFAULT;
         status_q <= '0;
         rd_q     <= '0;
         rd_vld_q <= 1'b0;
         wr_ack_q <= 1'b0;
         int_q    <= 1'b0;
      end else begin
         src_q    <= int_src;
         status_q <= status_nxt;
         rd_vld_q <= rd_acc;
         wr_ack_q <= wr_acc;
         int_q    <= |(status_q & enable_q);
         if (wr_acc && (reg_addr == ADDR_ENABLE)) begin
            enable_q <= reg_wr_data[INT_NUM-1:0];
         end
         if (rd_acc) begin
            rd_q <= rd_word;
         end
      end
   end

   assign reg_rd_out     = rd_q;
   assign reg_rd_vld     = rd_vld_q;
   assign reg_wr_ack     = wr_ack_q;
   assign int_enable_out = enable_q;
   assign int_status_out = status_q;
   assign int_out        = int_q;

endmodule

// File: tb/tb_reg_register_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_register_int_ctrl
//
// Bench for reg_register_int_ctrl with ENABLE_DEFAULT = 8'h05 and channel 1
// in level mode (all others edge mode). A cycle-level reference model tracks
// the register file from the documented rules; every cycle all outputs are
// compared against it, plus directed checks against literal values.
// ---------------------------------------------------------------------------
module tb_reg_register_int_ctrl;

   localparam int         W      = 32;
   localparam int         N      = 8;
   localparam logic [7:0] EDGE_P = 8'hFD;
   localparam logic [7:0] EN_DEF = 8'h05;

   // clock / reset
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0] int_src     = '0;
   logic         reg_wr_sel  = 1'b0;
   logic         reg_wr_rd   = 1'b0;
   logic [1:0]   reg_addr    = '0;
   logic [W-1:0] reg_wr_data = '0;
   logic [W-1:0] reg_rd_out;
   logic         reg_rd_vld;
   logic         reg_wr_ack;
   logic [N-1:0] int_enable_out;
   logic [N-1:0] int_status_out;
   logic         int_out;

   reg_register_int_ctrl #(
      .REG_WIDTH      (W),
      .INT_NUM        (N),
      .INT_EDGE       (EDGE_P),
      .ENABLE_DEFAULT (EN_DEF)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .int_src        (int_src),
      .reg_wr_sel     (reg_wr_sel),
      .reg_wr_rd      (reg_wr_rd),
      .reg_addr       (reg_addr),
      .reg_wr_data    (reg_wr_data),
      .reg_rd_out     (reg_rd_out),
      .reg_rd_vld     (reg_rd_vld),
      .reg_wr_ack     (reg_wr_ack),
      .int_enable_out (int_enable_out),
      .int_status_out (int_status_out),
      .int_out        (int_out)
   );

   // scoreboard counters
   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [N-1:0] m_en, m_st, m_prev;
   logic [W-1:0] m_rd;
   logic         m_vld, m_ack, m_int;
   logic [W-1:0] exp_q[$];   // expected read results, in order

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_en = EN_DEF; m_st = '0; m_prev = '0;
      m_rd = '0; m_vld = 1'b0; m_ack = 1'b0; m_int = 1'b0;
      exp_q.delete();
   endtask

   // One clock edge of the documented behaviour, from the sampled inputs.
   task automatic model_edge(input logic [N-1:0] src, input logic sel, input logic wr,
                             input logic [1:0] addr, input logic [W-1:0] data);
      logic [N-1:0] ev;
      logic [N-1:0] new_st;
      logic [W-1:0] rv;
      for (int i = 0; i < N; i++) begin
         if (EDGE_P[i]) ev[i] = src[i] && !m_prev[i];
         else           ev[i] = src[i];
      end
      m_int = (m_st & m_en) != 0;
      new_st = m_st;
      if (sel && wr && addr == 2'd1) new_st = m_st & ~data[N-1:0];
      new_st = new_st | ev;
      m_vld = sel && !wr;
      m_ack = sel && wr;
      if (sel && !wr) begin
         rv = 0;
         if (addr == 2'd0) rv = W'(m_en);
         if (addr == 2'd1) rv = W'(m_st);
         if (addr == 2'd2) rv = W'(m_prev);
         exp_q.push_back(rv);
      end
      if (sel && wr && addr == 2'd0) m_en = data[N-1:0];
      m_st = new_st;
      m_prev = src;
   endtask

   task automatic check_all();
      check("rd_vld", W'(reg_rd_vld), W'(m_vld));
      check("wr_ack", W'(reg_wr_ack), W'(m_ack));
      check("enable", W'(int_enable_out), W'(m_en));
      check("status", W'(int_status_out), W'(m_st));
      check("int_out", W'(int_out), W'(m_int));
      if (m_vld) begin
         if (exp_q.size() == 0) begin
            check("rd_queue", 1, 0);
         end else begin
            m_rd = exp_q.pop_front();
         end
      end
      check("rd_out", reg_rd_out, m_rd);
   endtask

   // driver: apply inputs, take one edge, compare #1 later
   task automatic cyc(input logic [N-1:0] src, input logic sel, input logic wr,
                      input logic [1:0] addr, input logic [W-1:0] data);
      int_src = src; reg_wr_sel = sel; reg_wr_rd = wr;
      reg_addr = addr; reg_wr_data = data;
      @(posedge clk);
      model_edge(src, sel, wr, addr, data);
      #1;
      check_all();
   endtask

   task automatic idle(input logic [N-1:0] src, input int n);
      for (int k = 0; k < n; k++) cyc(src, 1'b0, 1'b0, 2'd0, '0);
   endtask

   task automatic wr_reg(input logic [N-1:0] src, input logic [1:0] addr, input logic [W-1:0] data);
      cyc(src, 1'b1, 1'b1, addr, data);
   endtask

   task automatic rd_reg(input logic [N-1:0] src, input logic [1:0] addr);
      cyc(src, 1'b1, 1'b0, addr, '0);
   endtask

   initial begin
      model_reset();
      // reset and defaults
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
      idle('0, 1);
      rd_reg('0, 2'd0);
      check("rst_en_read", reg_rd_out, 32'h5);
      check("rst_en_vld", W'(reg_rd_vld), 1);
      idle('0, 1);
      check("rst_vld_drop", W'(reg_rd_vld), 0);
      check("rst_int", W'(int_out), 0);

      // edge detect and interrupt on channel 0
      wr_reg('0, 2'd0, 32'h1);
      cyc(8'h01, 1'b0, 1'b0, 2'd0, '0);
      check("edge_status", W'(int_status_out), 32'h01);
      check("edge_int_early", W'(int_out), 0);
      idle(8'h01, 1);
      check("edge_int", W'(int_out), 1);
      wr_reg(8'h01, 2'd1, 32'h1);
      check("w1c_status", W'(int_status_out), 0);
      idle(8'h01, 1);
      check("w1c_int", W'(int_out), 0);
      idle(8'h01, 1);
      idle('0, 2);

      // level channel 1: set wins over clear while source is high
      idle(8'h02, 2);
      wr_reg(8'h02, 2'd1, 32'h2);
      check("lvl_hold", W'(int_status_out[1]), 1);
      rd_reg(8'h02, 2'd1);
      idle('0, 1);
      wr_reg('0, 2'd1, 32'h2);
      check("lvl_clear", W'(int_status_out[1]), 0);

      // masking on channel 3
      wr_reg('0, 2'd0, 32'h0);
      cyc(8'h08, 1'b0, 1'b0, 2'd0, '0);
      idle('0, 2);
      check("mask_status", W'(int_status_out), 32'h08);
      check("mask_int", W'(int_out), 0);
      wr_reg('0, 2'd0, 32'h8);
      check("unmask_int_early", W'(int_out), 0);
      idle('0, 1);
      check("unmask_int", W'(int_out), 1);
      wr_reg('0, 2'd1, 32'hFF);
      idle('0, 2);

      // reserved / read-only addresses and upper bits
      wr_reg('0, 2'd3, 32'hFFFF_FFFF);
      check("wr3_ack", W'(reg_wr_ack), 1);
      wr_reg('0, 2'd2, 32'hFFFF_FFFF);
      check("wr2_ack", W'(reg_wr_ack), 1);
      check("wr2_en", W'(int_enable_out), 32'h08);
      rd_reg('0, 2'd3);
      check("rd3_zero", reg_rd_out, 32'h0);
      wr_reg('0, 2'd0, 32'hFFFF_FFFF);
      rd_reg('0, 2'd0);
      check("en_upper", reg_rd_out, 32'h0000_00FF);
      cyc(8'hA4, 1'b0, 1'b0, 2'd0, '0);
      rd_reg(8'hA4, 2'd2);
      check("raw_read", reg_rd_out, 32'hA4);

      // reset in the cycle after a read access
      int_src = 8'h10; reg_wr_sel = 1'b1; reg_wr_rd = 1'b0; reg_addr = 2'd1;
      @(posedge clk);
      model_edge(8'h10, 1'b1, 1'b0, 2'd1, '0);
      #1;
      check_all();
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      check("midrst_vld", W'(reg_rd_vld), 0);
      check("midrst_rd", reg_rd_out, 0);
      reg_wr_sel = 1'b0;
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
      rd_reg('0, 2'd0);
      check("post_rst_read", reg_rd_out, 32'h5);

      // randomized traffic
      for (int t = 0; t < 400; t++) begin
         logic [N-1:0] s;
         logic [W-1:0] d;
         s = N'($urandom) & N'($urandom);
         d = $urandom;
         if ($urandom_range(0, 3) == 0) cyc(s, 1'b0, 1'b0, 2'($urandom_range(0, 3)), d);
         else cyc(s, 1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reg_register_int_ctrl.md
# reg_register_int_ctrl

Parametrised interrupt controller register bank for the VT100 register layer. It holds three registers per instance: ENABLE, STATUS and RAW, for INT_NUM interrupt channels. Each channel is configurable for edge or level detection. STATUS bits are sticky and write-1-to-clear, and a single registered interrupt line is driven to the CPU-side logic. It uses the same single-select register access handshake as the single-field register blocks, adds a register address, and returns read data registered with a valid strobe.

## Interface
- REG_WIDTH, 32, register data width
- INT_NUM, 8, number of interrupt channels; legal range 1..REG_WIDTH
- INT_EDGE, {INT_NUM{1'b1}}, per-channel mode; bit i = 1 selects rising-edge detect, bit i = 0 selects level detect
- ENABLE_DEFAULT, {INT_NUM{1'b0}}, reset value of ENABLE

- clk  in  1  single clock for the block
- rst  in  1  reset, asynchronous, active-high
- int_src  in  INT_NUM  raw interrupt sources; already synchronous to clk
- reg_wr_sel  in  1  register access select
- reg_wr_rd  in  1  access direction; 1 = write, 0 = read
- reg_addr  in  2  register select; 0 = ENABLE (RW), 1 = STATUS (W1C), 2 = RAW (RO), 3 = reserved
- reg_wr_data  in  REG_WIDTH  write data
- reg_rd_out  out  REG_WIDTH  registered read data
- reg_rd_vld  out  1  one-cycle pulse; reg_rd_out is valid
- reg_wr_ack  out  1  one-cycle pulse one cycle after any write access
- int_enable_out  out  INT_NUM  current ENABLE contents
- int_status_out  out  INT_NUM  current STATUS contents
- int_out  out  1  registered OR of (STATUS & ENABLE)

## Operation
- Access decode:
  - write = reg_wr_sel & reg_wr_rd
  - read = reg_wr_sel & ~reg_wr_rd
- Source history: src_q <= int_src every cycle.
- Per-channel event:
  - edge channels: int_src[i] & ~src_q[i]
  - level channels: int_src[i]
- ENABLE: a write to addr 0 loads reg_wr_data[INT_NUM-1:0].
- STATUS[i]:
  - set on an event
  - cleared by a write to addr 1 with reg_wr_data[i] = 1
  - set has priority over clear in the same cycle
  - captured regardless of ENABLE; ENABLE masks only int_out
- RAW is read-only and returns src_q.
- Writes to addr 2 or 3 have no effect on state, but reg_wr_ack still pulses.
- Read data:
  - selected register, zero-extended; bits [REG_WIDTH-1:INT_NUM] read 0
  - addr 3 reads 0
  - value is the pre-update contents at the access edge
- reg_rd_out holds its last value between reads.
- int_out <= |(STATUS & ENABLE), using the current register values.
- Reset (asserted at any time, including mid-access):
  - all state clears immediately
  - ENABLE = ENABLE_DEFAULT
  - STATUS, src_q, reg_rd_out, reg_rd_vld, reg_wr_ack and int_out = 0
  - any in-flight access is dropped; no vld or ack is produced for it

## Timing
- Source rises and is sampled at edge N:
  - STATUS bit = 1 after edge N
  - int_out = 1 after edge N+1, provided ENABLE is set
- Read access sampled at edge N: reg_rd_out is updated and reg_rd_vld = 1 during cycle N+1 only.
- Write access sampled at edge N:
  - the register is updated after edge N
  - reg_wr_ack = 1 during cycle N+1
  - int_out reflects the change after edge N+1
- Back-to-back accesses are accepted every cycle. There is no backpressure.
- A read of STATUS in the same cycle as an event returns the old value; the next read shows the new bit.
- Level channel with its source still high: a W1C does not clear the bit, because set wins.
- Edge channel with its source held high: exactly one event; a W1C then clears the bit permanently until the next rising edge.

## Test plan
- Reset and defaults:
  - rst pulse with ENABLE_DEFAULT = 8'h05
  - read addr 0 -> reg_rd_out = 32'h5 with reg_rd_vld for one cycle
  - STATUS = 0, int_out = 0
- Edge detect and interrupt:
  - write ENABLE = 8'h01, then hold int_src[0] high for 5 cycles
  - STATUS = 8'h01 one cycle after the rise; int_out = 1 one cycle later
  - W1C 32'h1 -> STATUS = 0 and int_out = 0 two cycles after the write, with int_src still high
- Level mode with set/clear collision:
  - set INT_EDGE[1] = 0 and hold int_src[1] high
  - W1C 32'h2 -> STATUS[1] stays 1
  - drop int_src[1], then W1C -> STATUS[1] = 0
- Masking:
  - with ENABLE = 0, pulse int_src[3] -> STATUS = 8'h08, int_out = 0
  - write ENABLE = 8'h08 -> int_out = 1 two edges after the write access
- Reserved and upper bits:
  - write 32'hFFFF_FFFF to addr 3 and to addr 2 -> no state change, reg_wr_ack pulses each time
  - read addr 3 -> 0
  - read ENABLE after writing 32'hFFFF_FFFF -> 32'h0000_00FF
- Reset mid-operation:
  - assert rst in the cycle after a read access -> reg_rd_vld = 0 and all outputs = reset values
  - after release, a normal read returns correct data
